// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants and fetch FSM encoding used by the front end and decoder.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {instr, pc} FIFO; entry 0 is always the head, so a pop shifts entry 1 down.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] push_instr_i,
    input  logic [XLEN-1:0] push_pc_i,
    output logic [XLEN-1:0] head_instr_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [XLEN-1:0] instr_q [2];
    logic [XLEN-1:0] pc_q    [2];
    logic [1:0]      cnt_q;
    logic            wr, rd;

    assign full_o       = (cnt_q == 2'(DEPTH));
    assign empty_o      = (cnt_q == 2'd0);
    assign rd           = pop_i && !empty_o;
    assign wr           = push_i && (!full_o || rd);
    assign head_instr_o = instr_q[0];
    assign head_pc_o    = pc_q[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            instr_q[0] <= NOP_INSTR;
            instr_q[1] <= NOP_INSTR;
            pc_q[0]    <= RESET_PC;
            pc_q[1]    <= RESET_PC;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else begin
            if (rd && cnt_q == 2'd2) begin
                instr_q[0] <= instr_q[1];
                pc_q[0]    <= pc_q[1];
            end
            // New word lands at the head when the queue is (or is about to become) empty.
            if (wr) begin
                if (cnt_q == 2'd0 || (cnt_q == 2'd1 && rd)) begin
                    instr_q[0] <= push_instr_i;
                    pc_q[0]    <= push_pc_i;
                end else begin
                    instr_q[1] <= push_instr_i;
                    pc_q[1]    <= push_pc_i;
                end
            end
            cnt_q <= cnt_q + {1'b0, wr} - {1'b0, rd};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem request, 2-entry queue, redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
`endif
    output logic [6:0]      opcode
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            drop_q, req_q;
    logic            accept, push, pop, q_empty, q_full;
    logic [XLEN-1:0] head_instr;
    logic            unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign accept = req_q && imem_req_ready;
    assign pop    = instr_valid && instr_ready && !redirect_valid;
    assign push   = (state_q == WAIT) && imem_resp_valid && !drop_q && !redirect_valid;

    fetch_queue #(.XLEN(XLEN), .DEPTH(QDEPTH), .RESET_PC(RESET_PC)) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_instr_i(imem_resp_data),
        .push_pc_i   (pc_q),
        .head_instr_o(head_instr),
        .head_pc_o   (instr_pc),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    assign imem_req_valid = req_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = !q_empty;
    assign instr          = q_empty ? NOP_INSTR : head_instr;
    assign opcode         = instr[6:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            // Park in WAIT while a stale response is still owed; a response landing now settles it.
            if ((drop_q && !imem_resp_valid) ||
                (!drop_q && ((state_q == WAIT && !imem_resp_valid) || accept))) begin
                drop_q  <= 1'b1;
                state_q <= WAIT;
                req_q   <= 1'b0;
            end else begin
                drop_q  <= 1'b0;
                state_q <= REQ;
                req_q   <= 1'b1;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (accept) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            pc_q <= pc_q + XLEN'(4);
                            if (q_empty || pop) begin
                                state_q <= REQ;
                                req_q   <= 1'b1;
                            end else begin
                                state_q <= FULL;
                            end
                        end
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= REQ;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            if (push)              fetched_q <= fetched_q + 32'd1;
            if (state_q == FULL)   stall_q   <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

    logic unused_full;
    assign unused_full = q_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for streaming/backpressure, hand sequences for redirects.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr, imem_resp_data;
    logic        imem_resp_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  opcode;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode)
    );

    int checks = 0;
    int errors = 0;

    // sampled outputs of the current cycle
    logic        s_req, s_iv;
    logic [31:0] s_addr, s_ipc, s_instr;
    logic [6:0]  s_op;

    // memory model state
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_p = '0;

    // pop log
    int          npops = 0;
    logic [31:0] first_pop_pc = 32'hffff_ffff;
    logic        saw_pc8 = 1'b0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        if (a == 32'h4) return 32'h0000_2003;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        npops = 0;
        first_pop_pc = 32'hffff_ffff;
        saw_pc8 = 1'b0;
    endtask

    // One cycle: sample outputs at negedge, then drive this cycle's inputs.
    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rst);
        @(negedge clk);
        s_req = imem_req_valid; s_addr = imem_addr;
        s_iv = instr_valid; s_ipc = instr_pc; s_instr = instr; s_op = opcode;
        imem_resp_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memword(mem_addr_p);
            end
        end
        if (s_req && imem_req_ready) begin
            mem_cnt = mem_lat;
            mem_addr_p = s_addr;
        end
        if (rst) mem_cnt = 0;
        instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc; rst_n = !rst;
        if (s_iv && rdy && !redir && !rst) begin
            if (npops == 0) first_pop_pc = s_ipc;
            if (s_ipc == 32'h8) saw_pc8 = 1'b1;
            npops++;
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] epc;
        logic [6:0]  eop;
    } vec_t;

    function automatic vec_t mk(logic rst, logic rdy, logic ereq, logic [31:0] eaddr,
                                logic eiv, logic [31:0] epc, logic [6:0] eop);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.ereq = ereq; v.eaddr = eaddr;
        v.eiv = eiv; v.epc = epc; v.eop = eop;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vq[$];
        logic found;
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        // streaming with ready=1, reset while a response is pending, then backpressure
        vq.push_back(mk(1, 1, 0, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 1, 0, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 1, 1, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 1, 0, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 1, 1, 32'h4, 1, 32'h0, 7'b0110011));
        vq.push_back(mk(0, 1, 0, 32'h4, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 1, 1, 32'h8, 1, 32'h4, 7'b0000011));
        vq.push_back(mk(1, 0, 0, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 0, 0, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 0, 1, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 0, 0, 32'h0, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 0, 1, 32'h4, 1, 32'h0, 7'b0110011));
        vq.push_back(mk(0, 0, 0, 32'h4, 1, 32'h0, 7'b0110011));
        for (int i = 0; i < 8; i++) vq.push_back(mk(0, 0, 0, 32'h8, 1, 32'h0, 7'b0110011));
        vq.push_back(mk(0, 1, 0, 32'h8, 1, 32'h0, 7'b0110011));
        vq.push_back(mk(0, 1, 1, 32'h8, 1, 32'h4, 7'b0000011));
        vq.push_back(mk(0, 1, 0, 32'h8, 0, 32'h0, 7'b0010011));
        vq.push_back(mk(0, 1, 1, 32'hc, 1, 32'h8, 7'b0010011));

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].rdy, 1'b0, 32'h0, vq[i].rst);
            if (!vq[i].rst) begin
                chk($sformatf("row%0d req_valid", i), {31'b0, s_req}, {31'b0, vq[i].ereq});
                chk($sformatf("row%0d addr", i), s_addr, vq[i].eaddr);
                chk($sformatf("row%0d instr_valid", i), {31'b0, s_iv}, {31'b0, vq[i].eiv});
                chk($sformatf("row%0d opcode", i), {25'b0, s_op}, {25'b0, vq[i].eop});
                if (vq[i].eiv) chk($sformatf("row%0d instr_pc", i), s_ipc, vq[i].epc);
                else           chk($sformatf("row%0d nop", i), s_instr, 32'h0000_0013);
            end
        end

        // redirect while waiting on addr 0x8 (2-cycle memory): response dropped
        mem_lat = 2;
        cyc(1, 0, 0, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1, 0, 0, 0);
            if (s_req && s_addr == 32'h8) found = 1'b1;
        end
        chk("t3 reach addr8", {31'b0, found}, 32'h1);
        cyc(1, 1, 32'h100, 0);
        clear_log();
        cyc(1, 0, 0, 0);
        chk("t3 drop req_valid", {31'b0, s_req}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("t3 req_valid", {31'b0, s_req}, 32'h1);
        chk("t3 addr", s_addr, 32'h100);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        chk("t3 no pc8", {31'b0, saw_pc8}, 32'h0);
        chk("t3 first pop pc", first_pop_pc, 32'h100);

        // redirect coinciding with response and pop
        mem_lat = 1;
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 32'h40, 0);
        chk("t4 head before redirect", {31'b0, s_iv}, 32'h1);
        clear_log();
        cyc(1, 0, 0, 0);
        chk("t4 empty", {31'b0, s_iv}, 32'h0);
        chk("t4 req_valid", {31'b0, s_req}, 32'h1);
        chk("t4 addr", s_addr, 32'h40);
        cyc(1, 0, 0, 0);
        chk("t4 still empty", {31'b0, s_iv}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("t4 valid", {31'b0, s_iv}, 32'h1);
        chk("t4 pc", s_ipc, 32'h40);
        chk("t4 instr", s_instr, 32'h0000_4013);

        // misaligned redirect from FULL, then redirect in REQ as request is accepted
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h203, 0);
        chk("t5 full no req", {31'b0, s_req}, 32'h0);
        chk("t5 full valid", {31'b0, s_iv}, 32'h1);
        cyc(1, 1, 32'h300, 0);
        chk("t5 req_valid", {31'b0, s_req}, 32'h1);
        chk("t5 aligned addr", s_addr, 32'h200);
        chk("t5 flushed", {31'b0, s_iv}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("t5 drop req_valid", {31'b0, s_req}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("t5 req after drop", {31'b0, s_req}, 32'h1);
        chk("t5 addr after drop", s_addr, 32'h300);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t5 valid", {31'b0, s_iv}, 32'h1);
        chk("t5 pc", s_ipc, 32'h300);
        chk("t5 instr", s_instr, 32'h0003_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
